// File: rtl/noc_pkg.sv
// Shared NoC constants: packet width, header field positions and arbiter pointer encoding.
package noc_pkg;

    localparam int unsigned PAC_WIDTH = 64;
    localparam int unsigned VC_BIT    = 63;
    localparam int unsigned DIR_BIT   = 62;
    localparam int unsigned HOP_MSB   = 55;
    localparam int unsigned HOP_LSB   = 48;

    // Which requester wins the next contested grant.
    typedef enum logic {
        PtrCw  = 1'b0,
        PtrCcw = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is cw, requester 1 is ccw.
// The pointer only moves on a contested grant, and then it favours the loser.
module rr_arb2
    import noc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    rr_ptr_e ptr_q, ptr_d;

    // Grant decode and pointer next-state.
    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        unique case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                if (ptr_q == PtrCw) begin
                    gnt_o = 2'b01;
                    ptr_d = PtrCcw;
                end else begin
                    gnt_o = 2'b10;
                    ptr_d = PtrCw;
                end
            end
            default: ;
        endcase
    end

    // Pointer register; reset favours cw.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PtrCw;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_vc_arbiter.sv
// Output port of a two-VC ring router. Each phase the internal VC (= polarity) buffer is
// filled from the cw/ccw input buffers while the external VC (= ~polarity) buffer drains
// downstream, so fill and drain never touch the same entry.
module output_vc_arbiter #(
    parameter int unsigned PAC_WIDTH = noc_pkg::PAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 polarity,
    input  logic                 cwreq,
    input  logic [PAC_WIDTH-1:0] cwdata,
    output logic                 cwgnt,
    input  logic                 ccwreq,
    input  logic [PAC_WIDTH-1:0] ccwdata,
    output logic                 ccwgnt,
    output logic                 so,
    input  logic                 ro,
    output logic [PAC_WIDTH-1:0] dout
);

    import noc_pkg::*;

    logic [1:0][PAC_WIDTH-1:0] buf_q, buf_d;
    logic [1:0]                full_q, full_d;

    logic       int_vc, ext_vc;
    logic       cw_elig, ccw_elig;
    logic [1:0] req_vc0, req_vc1;
    logic [1:0] gnt_vc0, gnt_vc1;
    logic [1:0] gnt;

    assign int_vc = polarity;
    assign ext_vc = ~polarity;

    // Grants are suppressed while reset is held, even though the buffers already read empty.
    assign cw_elig  = cwreq  & (cwdata[VC_BIT]  == polarity) & ~full_q[int_vc] & ~reset;
    assign ccw_elig = ccwreq & (ccwdata[VC_BIT] == polarity) & ~full_q[int_vc] & ~reset;

    // Only the arbiter of the current internal VC sees requests, so the other pointer holds.
    assign req_vc0 = {ccw_elig, cw_elig} & {2{~polarity}};
    assign req_vc1 = {ccw_elig, cw_elig} & {2{polarity}};

    rr_arb2 u_arb_vc0 (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (req_vc0),
        .gnt_o (gnt_vc0)
    );

    rr_arb2 u_arb_vc1 (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (req_vc1),
        .gnt_o (gnt_vc1)
    );

    assign gnt    = polarity ? gnt_vc1 : gnt_vc0;
    assign cwgnt  = gnt[0];
    assign ccwgnt = gnt[1];

    assign so   = full_q[ext_vc];
    assign dout = so ? buf_q[ext_vc] : '0;

    // Buffer next-state: drain the external entry, fill the internal entry.
    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        if (so && ro) begin
            full_d[ext_vc] = 1'b0;
        end
        if (|gnt) begin
            full_d[int_vc] = 1'b1;
            buf_d[int_vc]  = gnt[0] ? cwdata : ccwdata;
        end
    end

    // Buffer and full-flag registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            full_q <= '0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
        end
    end

endmodule

// File: doc/output_vc_arbiter.md
OUTPUT_VC_ARBITER -- requirements
Module: output_vc_arbiter

Interface
REQ-001 Parameter: PAC_WIDTH, default 64, packet width in bits.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 polarity  input  1  router phase; toggles each cycle outside reset.
REQ-005 cwreq  input  1  cw input buffer requests this output.
REQ-006 cwdata  input  PAC_WIDTH  cw candidate packet (bit 63 = VC).
REQ-007 cwgnt  output  1  cw packet accepted at this posedge.
REQ-008 ccwreq  input  1  ccw input buffer requests this output.
REQ-009 ccwdata  input  PAC_WIDTH  ccw candidate packet.
REQ-010 ccwgnt  output  1  ccw packet accepted at this posedge.
REQ-011 so  output  1  send-out valid to downstream.
REQ-012 ro  input  1  downstream ready.
REQ-013 dout  output  PAC_WIDTH  packet to downstream.

Function
REQ-014 Block SHALL hold two one-entry output buffers, buf[0] and buf[1], one per VC, each with a full flag.
REQ-015 Internal VC SHALL equal polarity; external VC SHALL equal ~polarity.
REQ-016 A requester SHALL be eligible when req=1, data[63]==polarity and buf[polarity] is empty.
REQ-017 Exactly one eligible requester SHALL be granted; grants SHALL be combinational in the same cycle.
REQ-018 With both eligible, winner SHALL be chosen by the round-robin pointer of VC polarity; pointer SHALL flip to favour the loser after each contested grant.
REQ-019 Uncontested grants SHALL leave the pointer unchanged.
REQ-020 On a grant, buf[polarity] SHALL capture the winner's data unmodified and set full at the same posedge.
REQ-021 so SHALL equal full[~polarity]; dout SHALL equal buf[~polarity] when so=1, else 0.
REQ-022 When so=1 and ro=1, full[~polarity] SHALL clear at that posedge (1-cycle transfer).
REQ-023 ro=0 SHALL hold the external buffer; it SHALL be offered again two cycles later.
REQ-024 Fill and drain address different buffers each cycle; simultaneous fill and drain SHALL both complete.
REQ-025 Requests with data[63]!=polarity SHALL receive no grant that cycle.
REQ-026 Minimum latency grant to so=1 SHALL be exactly 1 cycle (next phase).

Reset
REQ-027 reset=1 SHALL asynchronously clear both full flags and buffer data to 0.
REQ-028 reset=1 SHALL set both round-robin pointers to favour cw.
REQ-029 During reset cwgnt, ccwgnt, so SHALL be 0 and dout SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered packets; no partial output.

Structure
REQ-031 noc_pkg SHALL hold PAC_WIDTH, VC_BIT=63, DIR_BIT=62, HOP_MSB=55, HOP_LSB=48.
REQ-032 Arbitration SHALL be a sub-module rr_arb2 (2 requesters, pointer, grant), instanced once per VC.
REQ-033 No latches; all state SHALL be flip-flops with async reset.

Verification
REQ-034 Reset 3 cycles, release, polarity=0, cwreq=1 cwdata=0x0001_0000_0000_1234 -> cwgnt=1 that cycle; next cycle so=1, dout=0x0001_0000_0000_1234.
REQ-035 polarity=1, both req, data[63]=1, pointer=cw -> cwgnt=1, ccwgnt=0; next VC1 contest -> ccwgnt=1.
REQ-036 polarity=0, cwdata[63]=1 -> no grant; held until polarity=1 -> cwgnt=1.
REQ-037 buf[0] full, ro=0 for 4 cycles -> so=1 on odd-phase cycles, dout stable, no new VC0 grants; ro=1 -> so drops after transfer.
REQ-038 Alternating cwdata[63] with hop=0x01 for 10 cycles, ro=1 -> 10 packets out in order, 1-cycle latency each, none lost.
REQ-039 reset asserted with both buffers full -> so=0, grants 0 immediately; after release first packet treated as new.
